// File: rtl/cpu_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects,
// stage indices and scoreboard entry layout helpers.
package cpu_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_MEM = 3;

  localparam int unsigned STALL_CNT_W = 3;
  localparam int unsigned SB_FLAG_W   = 2;  // reg_write, is_load
  localparam int unsigned SB_USE_W    = 2;  // uses_rs, uses_rt

  // EX entry: rs, rt, use bits, dst, flags
  function automatic int unsigned sb_ex_w(input int unsigned aw);
    return 3 * aw + SB_USE_W + SB_FLAG_W;
  endfunction

  // MEM entry: dst, flags
  function automatic int unsigned sb_mem_w(input int unsigned aw);
    return aw + SB_FLAG_W;
  endfunction

  // WB entry: dst, reg_write (load flag is dead past MEM)
  function automatic int unsigned sb_wb_w(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard entry: a valid bit plus payload, advanced on enable,
// cleared to a bubble when i_clr is set in an enabled cycle.
module hazard_sb_stage #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= i_valid;
        r_data  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage core. Tracks
// in-flight writers for EX/MEM/WB and derives stalls, flushes and fwd selects.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned BRANCH_STAGE = 3,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned FWD_EN       = 1,
  parameter int unsigned PERF_W       = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  redirect,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
);

  localparam int unsigned EX_W  = sb_ex_w(REG_ADDR_W);
  localparam int unsigned MEM_W = sb_mem_w(REG_ADDR_W);
  localparam int unsigned WB_W  = sb_wb_w(REG_ADDR_W);

  logic [EX_W-1:0]        w_ex_data;
  logic [MEM_W-1:0]       w_mem_data;
  logic [WB_W-1:0]        w_wb_data;
  logic                   w_ex_valid, w_mem_valid, w_wb_valid;
  logic [REG_ADDR_W-1:0]  w_ex_rs, w_ex_rt, w_ex_dst, w_mem_dst, w_wb_dst;
  logic                   w_ex_uses_rs, w_ex_uses_rt, w_ex_rw, w_ex_ld;
  logic                   w_mem_rw, w_mem_ld, w_wb_rw;
  logic                   w_hit_ex, w_hit_mem, w_hit_wb;
  logic                   w_load_use, w_raw_nf, w_stall;
  logic                   w_ex_clr, w_mem_clr;
  logic [1:0]             w_fwd_a, w_fwd_b;
  logic [STALL_CNT_W-1:0] r_lat_cnt;
  logic [PERF_W-1:0]      r_stall_cnt, r_flush_cnt;

  function automatic logic src_hit(input logic v, input logic use_src,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic pv, input logic pw,
                                   input logic [REG_ADDR_W-1:0] pdst);
    return v && use_src && (src != '0) && pv && pw && (src == pdst);
  endfunction

  assign w_ex_clr  = redirect || w_stall;
  assign w_mem_clr = redirect && (BRANCH_STAGE == STAGE_MEM);

  hazard_sb_stage #(.DATA_W(EX_W)) u_sb_ex (
    .clk(clk), .arst_n(arst_n), .i_en(enable), .i_clr(w_ex_clr), .i_valid(id_valid),
    .i_data({id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst, id_reg_write, id_mem_read}),
    .o_valid(w_ex_valid), .o_data(w_ex_data)
  );

  hazard_sb_stage #(.DATA_W(MEM_W)) u_sb_mem (
    .clk(clk), .arst_n(arst_n), .i_en(enable), .i_clr(w_mem_clr), .i_valid(w_ex_valid),
    .i_data({w_ex_dst, w_ex_rw, w_ex_ld}), .o_valid(w_mem_valid), .o_data(w_mem_data)
  );

  hazard_sb_stage #(.DATA_W(WB_W)) u_sb_wb (
    .clk(clk), .arst_n(arst_n), .i_en(enable), .i_clr(1'b0), .i_valid(w_mem_valid),
    .i_data({w_mem_dst, w_mem_rw}), .o_valid(w_wb_valid), .o_data(w_wb_data)
  );

  assign {w_ex_rs, w_ex_rt, w_ex_uses_rs, w_ex_uses_rt, w_ex_dst, w_ex_rw, w_ex_ld} = w_ex_data;
  assign {w_mem_dst, w_mem_rw, w_mem_ld} = w_mem_data;
  assign {w_wb_dst, w_wb_rw} = w_wb_data;

  // ID source against each in-flight writer
  assign w_hit_ex  = src_hit(id_valid, id_uses_rs, id_rs, w_ex_valid, w_ex_rw, w_ex_dst)
                   | src_hit(id_valid, id_uses_rt, id_rt, w_ex_valid, w_ex_rw, w_ex_dst);
  assign w_hit_mem = src_hit(id_valid, id_uses_rs, id_rs, w_mem_valid, w_mem_rw, w_mem_dst)
                   | src_hit(id_valid, id_uses_rt, id_rt, w_mem_valid, w_mem_rw, w_mem_dst);
  assign w_hit_wb  = src_hit(id_valid, id_uses_rs, id_rs, w_wb_valid, w_wb_rw, w_wb_dst)
                   | src_hit(id_valid, id_uses_rt, id_rt, w_wb_valid, w_wb_rw, w_wb_dst);

  assign w_load_use = (FWD_EN != 0) && w_hit_ex && w_ex_ld;
  assign w_raw_nf   = (FWD_EN == 0) && (w_hit_ex || w_hit_mem || w_hit_wb);
  assign w_stall    = (r_lat_cnt != '0) || w_load_use || w_raw_nf;

  // MEM carries alu_out, so a load there is never a forwarding source
  always_comb begin
    w_fwd_a = FWD_REG;
    w_fwd_b = FWD_REG;
    if (FWD_EN != 0) begin
      if (src_hit(w_ex_valid, w_ex_uses_rs, w_ex_rs, w_mem_valid, w_mem_rw && !w_mem_ld, w_mem_dst))
        w_fwd_a = FWD_MEM;
      else if (src_hit(w_ex_valid, w_ex_uses_rs, w_ex_rs, w_wb_valid, w_wb_rw, w_wb_dst))
        w_fwd_a = FWD_WB;
      if (src_hit(w_ex_valid, w_ex_uses_rt, w_ex_rt, w_mem_valid, w_mem_rw && !w_mem_ld, w_mem_dst))
        w_fwd_b = FWD_MEM;
      else if (src_hit(w_ex_valid, w_ex_uses_rt, w_ex_rt, w_wb_valid, w_wb_rw, w_wb_dst))
        w_fwd_b = FWD_WB;
    end
  end

  assign fwd_a = w_fwd_a;
  assign fwd_b = w_fwd_b;

  // Pipeline enables and flushes; redirect outranks any stall
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (arst_n) begin
      if (!enable) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
      end else if (redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = (BRANCH_STAGE == STAGE_MEM);
      end else if (w_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Remaining load-latency stall cycles after the detection cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_lat_cnt <= '0;
    end else if (enable) begin
      if (redirect)
        r_lat_cnt <= '0;
      else if (r_lat_cnt != '0)
        r_lat_cnt <= r_lat_cnt - STALL_CNT_W'(1);
      else if (w_load_use)
        r_lat_cnt <= STALL_CNT_W'(LOAD_LAT - 1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (enable) begin
      if (!redirect && w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three configurations (LOAD_LAT=1, LOAD_LAT=3,
// no-forward with BRANCH_STAGE=2 and 2-bit counters) share one stimulus stream.
module tb_hazard_ctrl;

  logic       clk;
  logic       arst_n, enable, redirect;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dst;

  logic       pc_en [3];
  logic       if_id_en [3];
  logic       if_id_flush [3];
  logic       id_ex_flush [3];
  logic       ex_mem_flush [3];
  logic [1:0] fwd_a [3];
  logic [1:0] fwd_b [3];
  logic [15:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int n_chk;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_STAGE(3), .LOAD_LAT(1), .FWD_EN(1), .PERF_W(16)) u_dut0 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .redirect(redirect), .pc_en(pc_en[0]), .if_id_en(if_id_en[0]),
    .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]), .ex_mem_flush(ex_mem_flush[0]),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_STAGE(3), .LOAD_LAT(3), .FWD_EN(1), .PERF_W(16)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .redirect(redirect), .pc_en(pc_en[1]), .if_id_en(if_id_en[1]),
    .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]), .ex_mem_flush(ex_mem_flush[1]),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_STAGE(2), .LOAD_LAT(1), .FWD_EN(0), .PERF_W(2)) u_dut2 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .redirect(redirect), .pc_en(pc_en[2]), .if_id_en(if_id_en[2]),
    .if_id_flush(if_id_flush[2]), .id_ex_flush(id_ex_flush[2]), .ex_mem_flush(ex_mem_flush[2]),
    .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic id_ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    id_ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    nop();
    redirect = 1'b0;
    enable   = 1'b1;
    arst_n   = 1'b0;
    #1;
    arst_n   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    // reset values with redirect and a live ID instruction pending
    arst_n = 1'b0; enable = 1'b1; redirect = 1'b1;
    id_ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    settle();
    chk("rst_pc_en", 32'(pc_en[0]), 32'd1);
    chk("rst_if_id_en", 32'(if_id_en[0]), 32'd1);
    chk("rst_if_id_flush", 32'(if_id_flush[0]), 32'd0);
    chk("rst_id_ex_flush", 32'(id_ex_flush[0]), 32'd0);
    chk("rst_ex_mem_flush", 32'(ex_mem_flush[0]), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a[0]), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt0), 32'd0);
    redirect = 1'b0;
    adv();
    arst_n = 1'b1;

    // A: add r3,r1,r2 ; sub r4,r3,r1 -> MEM forward
    rst_pulse();
    id_ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); adv();
    id_ins(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0); settle();
    chk("A_no_stall", 32'(pc_en[0]), 32'd1); adv();
    nop(); settle();
    chk("A_fwd_a_mem", 32'(fwd_a[0]), 32'd1);
    chk("A_fwd_b_reg", 32'(fwd_b[0]), 32'd0);
    adv();

    // B: add r3 ; add r0,r1,r1 ; or r5,r3,r0 -> WB forward, r0 never forwarded
    rst_pulse();
    id_ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); adv();
    id_ins(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0); adv();
    id_ins(1, 5'd3, 5'd0, 1, 1, 5'd5, 1, 0); settle();
    chk("B_no_stall", 32'(pc_en[0]), 32'd1); adv();
    nop(); settle();
    chk("B_fwd_a_wb", 32'(fwd_a[0]), 32'd2);
    chk("B_fwd_b_r0", 32'(fwd_b[0]), 32'd0);
    adv();

    // C: lw r2 ; add r4,r2,r2 with LOAD_LAT=1
    rst_pulse();
    id_ins(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); settle();
    chk("C_lw_pc_en", 32'(pc_en[0]), 32'd1); adv();
    id_ins(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0); settle();
    chk("C_stall_pc_en", 32'(pc_en[0]), 32'd0);
    chk("C_stall_id_ex_flush", 32'(id_ex_flush[0]), 32'd1);
    chk("C_stall_if_id_en", 32'(if_id_en[0]), 32'd0);
    adv(); settle();
    chk("C_release_pc_en", 32'(pc_en[0]), 32'd1);
    chk("C_release_flush", 32'(id_ex_flush[0]), 32'd0);
    adv();
    nop(); settle();
    chk("C_fwd_a_wb", 32'(fwd_a[0]), 32'd2);
    chk("C_fwd_b_wb", 32'(fwd_b[0]), 32'd2);
    chk("C_stall_cnt", 32'(stall_cnt0), 32'd1);
    adv();

    // D: LOAD_LAT=3 load-use with enable dropped for 4 cycles mid-stall
    rst_pulse();
    id_ins(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
    id_ins(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0); settle();
    chk("D_stall1", 32'(pc_en[1]), 32'd0); adv();
    settle();
    chk("D_stall2", 32'(pc_en[1]), 32'd0);
    chk("D_cnt_before_hold", 32'(stall_cnt1), 32'd1);
    adv();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("D_hold_pc_en", 32'(pc_en[1]), 32'd0);
      chk("D_hold_flush", 32'(id_ex_flush[1]), 32'd0);
      chk("D_hold_cnt", 32'(stall_cnt1), 32'd2);
      adv();
    end
    enable = 1'b1; settle();
    chk("D_resume_stall", 32'(pc_en[1]), 32'd0);
    chk("D_resume_flush", 32'(id_ex_flush[1]), 32'd1);
    adv(); settle();
    chk("D_done_pc_en", 32'(pc_en[1]), 32'd1);
    chk("D_stall_cnt", 32'(stall_cnt1), 32'd3);
    adv();

    // E: no-forward mode, 3-cycle RAW stalls; 2-bit counter saturates
    rst_pulse();
    id_ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); settle();
    chk("E_add_pc_en", 32'(pc_en[2]), 32'd1); adv();
    id_ins(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      settle(); chk("E_sub_stall", 32'(pc_en[2]), 32'd0); adv();
    end
    settle();
    chk("E_sub_issue", 32'(pc_en[2]), 32'd1);
    chk("E_stall_cnt3", 32'(stall_cnt2), 32'd3);
    adv();
    id_ins(1, 5'd4, 5'd4, 1, 1, 5'd6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("E_and_stall", 32'(pc_en[2]), 32'd0);
      if (i == 0) chk("E_fwd_held", 32'(fwd_a[2]), 32'd0);
      adv();
    end
    settle();
    chk("E_and_issue", 32'(pc_en[2]), 32'd1);
    chk("E_stall_cnt_sat", 32'(stall_cnt2), 32'd3);
    adv();

    // F: redirect during an active LOAD_LAT=3 stall
    rst_pulse();
    id_ins(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
    id_ins(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0); settle();
    chk("F_stall", 32'(pc_en[1]), 32'd0); adv();
    redirect = 1'b1; settle();
    chk("F_if_id_flush", 32'(if_id_flush[1]), 32'd1);
    chk("F_id_ex_flush", 32'(id_ex_flush[1]), 32'd1);
    chk("F_ex_mem_flush", 32'(ex_mem_flush[1]), 32'd1);
    chk("F_pc_en", 32'(pc_en[1]), 32'd1);
    chk("F_if_id_en", 32'(if_id_en[1]), 32'd1);
    chk("F_bs2_ex_mem_flush", 32'(ex_mem_flush[2]), 32'd0);
    chk("F_bs2_if_id_flush", 32'(if_id_flush[2]), 32'd1);
    adv();
    redirect = 1'b0; settle();
    chk("F_stall_ended", 32'(pc_en[1]), 32'd1);
    chk("F_flush_cnt", 32'(flush_cnt1), 32'd1);
    chk("F_stall_cnt", 32'(stall_cnt1), 32'd1);
    adv();

    // G: redirect with a producer in EX; only BRANCH_STAGE=3 drops it
    rst_pulse();
    id_ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); adv();
    nop(); redirect = 1'b1; settle();
    chk("G_ex_mem_flush", 32'(ex_mem_flush[0]), 32'd1); adv();
    redirect = 1'b0;
    id_ins(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0); settle();
    chk("G_bs2_keeps_writer", 32'(pc_en[2]), 32'd0);
    chk("G_bs3_pc_en", 32'(pc_en[0]), 32'd1);
    chk("G_flush_cnt", 32'(flush_cnt0), 32'd1);
    adv();
    nop(); settle();
    chk("G_flushed_no_fwd", 32'(fwd_a[0]), 32'd0);
    adv();

    // H: invalid ID and r0 sources never stall
    rst_pulse();
    id_ins(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
    id_ins(0, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0); settle();
    chk("H_invalid_id", 32'(pc_en[0]), 32'd1); adv();
    id_ins(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); adv();
    id_ins(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0); settle();
    chk("H_r0_load", 32'(pc_en[0]), 32'd1);
    adv();

    // I: reset asserted mid-stall
    rst_pulse();
    id_ins(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
    id_ins(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0); settle();
    chk("I_stall", 32'(pc_en[1]), 32'd0); adv();
    arst_n = 1'b0; settle();
    chk("I_in_reset_pc_en", 32'(pc_en[1]), 32'd1);
    chk("I_in_reset_cnt", 32'(stall_cnt1), 32'd0);
    adv();
    arst_n = 1'b1; settle();
    chk("I_after_pc_en", 32'(pc_en[1]), 32'd1);
    chk("I_after_flush", 32'(id_ex_flush[1]), 32'd0);
    adv();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
